// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline widths and write-back select encoding
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_SEL_W   = 2;
    localparam int RETIRE_W   = 32;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wb_sel_e;

    // Link instructions override loads: is_write_pc has priority over is_MemtoReg.
    function automatic wb_sel_e wb_sel_decode(input logic is_write_pc, input logic is_mem_to_reg);
        wb_sel_e sel;
        sel = WB_SEL_ALU;
        if (is_write_pc) begin
            sel = WB_SEL_PC;
        end else if (is_mem_to_reg) begin
            sel = WB_SEL_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_select.sv
// rtl/wb_select.sv - combinational 3:1 write-back data mux
module wb_select #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mem,
    input  logic [DATA_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_data
);
    import mips_pkg::*;

    // Pick the write-back source; the unused encoding falls back to the ALU path.
    always_comb begin
        o_data = i_alu;
        case (i_sel)
            WB_SEL_MEM: o_data = i_mem;
            WB_SEL_PC:  o_data = i_pc;
            default:    o_data = i_alu;
        endcase
    end

endmodule

// File: rtl/mem_wb_latch.sv
// rtl/mem_wb_latch.sv - MEM/WB pipeline register with flush/stall and optional RETIRE_COUNT_EN retire counter
module mem_wb_latch #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_output_mem,
    input  logic [DATA_W-1:0]     i_ALU_res,
    input  logic [DATA_W-1:0]     i_pc_to_reg,
    input  logic [REG_ADDR_W-1:0] i_addr_reg_dst,
    input  logic                  is_RegWrite,
    input  logic                  is_MemtoReg,
    input  logic                  is_write_pc,
    output logic [DATA_W-1:0]     o_wb_data,
    output logic [REG_ADDR_W-1:0] o_addr_reg_dst,
    output logic                  os_RegWrite,
    output logic                  o_valid,
    output logic [31:0]           o_retired
);
    import mips_pkg::*;

    wb_sel_e               wb_sel;
    logic [DATA_W-1:0]     wb_data_mux;
    logic                  reg_write_cap;

    logic [DATA_W-1:0]     wb_data_d,  wb_data_q;
    logic [REG_ADDR_W-1:0] reg_dst_d,  reg_dst_q;
    logic                  reg_write_d, reg_write_q;
    logic                  valid_d,    valid_q;

    // Decode the write-back source and suppress writes that can never land (bubble slot or r0).
    always_comb begin
        wb_sel        = wb_sel_decode(is_write_pc, is_MemtoReg);
        reg_write_cap = is_RegWrite & i_valid & (i_addr_reg_dst != '0);
    end

    // Select happens ahead of the register so o_wb_data comes straight from a flop.
    wb_select #(
        .DATA_W (DATA_W)
    ) u_wb_select (
        .i_sel  (wb_sel),
        .i_alu  (i_ALU_res),
        .i_mem  (i_output_mem),
        .i_pc   (i_pc_to_reg),
        .o_data (wb_data_mux)
    );

    // Next-state: flush beats stall, stall holds everything, otherwise capture.
    always_comb begin
        wb_data_d   = wb_data_q;
        reg_dst_d   = reg_dst_q;
        reg_write_d = reg_write_q;
        valid_d     = valid_q;
        if (i_flush) begin
            wb_data_d   = '0;
            reg_dst_d   = '0;
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
        end else if (i_enable) begin
            wb_data_d   = wb_data_mux;
            reg_dst_d   = i_addr_reg_dst;
            reg_write_d = reg_write_cap;
            valid_d     = i_valid;
        end
    end

    // Pipeline register; reset leaves a bubble, so nothing held before reset survives it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_data_q   <= '0;
            reg_dst_q   <= '0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            wb_data_q   <= wb_data_d;
            reg_dst_q   <= reg_dst_d;
            reg_write_q <= reg_write_d;
            valid_q     <= valid_d;
        end
    end

    // Outputs are the register contents directly.
    always_comb begin
        o_wb_data      = wb_data_q;
        o_addr_reg_dst = reg_dst_q;
        os_RegWrite    = reg_write_q;
        o_valid        = valid_q;
    end

`ifdef RETIRE_COUNT_EN
    logic [RETIRE_W-1:0] retired_d, retired_q;

    // Count every real instruction that actually advances into write-back; wraps silently.
    always_comb begin
        retired_d = retired_q;
        if (!i_flush && i_enable && i_valid) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    // Expose the count.
    always_comb begin
        o_retired = retired_q;
    end
`else
    // Counter disabled: constant zero, no state.
    always_comb begin
        o_retired = '0;
    end
`endif

endmodule
